// File: rtl/address_multiply_scheduler_if.sv
// Request, multiplier and result signals of address_multiply_scheduler.
// Define ADDR_MUL_SCHED_STATS_EN to add the grant/stall counter outputs.
interface address_multiply_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int DESTW = 3
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       i_req_v;
   logic [NREQ*32-1:0]    i_req_Aj;
   logic [NREQ*32-1:0]    i_req_Ak;
   logic [NREQ*DESTW-1:0] i_req_dest;
   logic [NREQ-1:0]       o_req_rdy;
   logic                  i_hold;
   logic [31:0]           o_mul_Aj;
   logic [31:0]           o_mul_Ak;
   logic                  o_mul_issue;
   logic [31:0]           i_mul_Ai;
   logic                  o_res_v;
   logic [IDW-1:0]        o_res_req;
   logic [DESTW-1:0]      o_res_dest;
   logic [31:0]           o_res_Ai;
   logic                  o_busy;
`ifdef ADDR_MUL_SCHED_STATS_EN
   logic [31:0]           o_issue_cnt;
   logic [31:0]           o_stall_cnt;
`endif

   // Handshake: request n transfers in a cycle where i_req_v[n] & o_req_rdy[n];
   // o_req_rdy is one-hot or zero. Results are single-cycle pulses with no backpressure.
   modport slave (
      input  i_req_v, i_req_Aj, i_req_Ak, i_req_dest, i_hold, i_mul_Ai,
      output o_req_rdy, o_mul_Aj, o_mul_Ak, o_mul_issue,
             o_res_v, o_res_req, o_res_dest, o_res_Ai, o_busy
`ifdef ADDR_MUL_SCHED_STATS_EN
      , output o_issue_cnt, o_stall_cnt
`endif
   );

   modport master (
      output i_req_v, i_req_Aj, i_req_Ak, i_req_dest, i_hold, i_mul_Ai,
      input  o_req_rdy, o_mul_Aj, o_mul_Ak, o_mul_issue,
             o_res_v, o_res_req, o_res_dest, o_res_Ai, o_busy
`ifdef ADDR_MUL_SCHED_STATS_EN
      , input o_issue_cnt, o_stall_cnt
`endif
   );
endinterface

// File: rtl/address_multiply_scheduler.sv
// Round-robin sharing of one pipelined address multiplier among NREQ requesters,
// with per-requester destination scoreboards. Optional counters: ADDR_MUL_SCHED_STATS_EN.
module address_multiply_scheduler #(
   parameter int NREQ    = 4,
   parameter int LATENCY = 6,
   parameter int DESTW   = 3
) (
   input logic                        clk,
   input logic                        i_rst_n,
   address_multiply_scheduler_if.slave bus
);
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int NDEST = 1 << DESTW;

   logic [IDW-1:0]                    ptr;
   logic [NREQ-1:0][NDEST-1:0]        sb;
   logic [LATENCY-1:0]                tag_v;
   logic [LATENCY-1:0][IDW-1:0]       tag_req;
   logic [LATENCY-1:0][DESTW-1:0]     tag_dest;

   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  grant;
   logic             found;
   logic [IDW-1:0]   gnt_id;
   logic [31:0]      gnt_aj;
   logic [31:0]      gnt_ak;
   logic [DESTW-1:0] gnt_dest;
   int               idx;

   // Gating with i_rst_n keeps o_req_rdy low while reset is asserted.
   always_comb begin
      elig = '0;
      for (int n = 0; n < NREQ; n++)
         elig[n] = i_rst_n & bus.i_req_v[n] & ~bus.i_hold &
                   ~sb[n][bus.i_req_dest[DESTW*n +: DESTW]];
   end

   always_comb begin
      grant    = '0;
      found    = 1'b0;
      gnt_id   = '0;
      gnt_aj   = '0;
      gnt_ak   = '0;
      gnt_dest = '0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && elig[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            gnt_id     = IDW'(idx);
            gnt_aj     = bus.i_req_Aj[32*idx +: 32];
            gnt_ak     = bus.i_req_Ak[32*idx +: 32];
            gnt_dest   = bus.i_req_dest[DESTW*idx +: DESTW];
         end
      end
   end

   assign bus.o_req_rdy   = grant;
   assign bus.o_mul_issue = found;
   assign bus.o_mul_Aj    = gnt_aj;
   assign bus.o_mul_Ak    = gnt_ak;

   // The product is only trusted when the matching tag reaches the last stage.
   assign bus.o_res_v    = tag_v[LATENCY-1];
   assign bus.o_res_req  = tag_req[LATENCY-1];
   assign bus.o_res_dest = tag_dest[LATENCY-1];
   assign bus.o_res_Ai   = tag_v[LATENCY-1] ? bus.i_mul_Ai : 32'd0;
   assign bus.o_busy     = (|tag_v) | (|sb);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr      <= '0;
         sb       <= '0;
         tag_v    <= '0;
         tag_req  <= '0;
         tag_dest <= '0;
      end else begin
         if (found) begin
            ptr                  <= (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + 1'b1;
            sb[gnt_id][gnt_dest] <= 1'b1;
         end
         // A grant requires its bit clear, so this never collides with the set above.
         if (tag_v[LATENCY-1])
            sb[tag_req[LATENCY-1]][tag_dest[LATENCY-1]] <= 1'b0;
         tag_v[0]    <= found;
         tag_req[0]  <= gnt_id;
         tag_dest[0] <= gnt_dest;
         for (int i = 1; i < LATENCY; i++) begin
            tag_v[i]    <= tag_v[i-1];
            tag_req[i]  <= tag_req[i-1];
            tag_dest[i] <= tag_dest[i-1];
         end
      end
   end

`ifdef ADDR_MUL_SCHED_STATS_EN
   logic [31:0] issue_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         issue_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (found)
            issue_cnt <= issue_cnt + 32'd1;
         if ((|bus.i_req_v) && !found)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign bus.o_issue_cnt = issue_cnt;
   assign bus.o_stall_cnt = stall_cnt;
`endif
endmodule

// File: tb/tb_address_multiply_scheduler.sv
// Randomized and directed bench for address_multiply_scheduler against a
// timestamp-based reference model; the multiplier is modelled as a delay line.
module tb_address_multiply_scheduler;
   localparam int NREQ    = 4;
   localparam int LATENCY = 6;
   localparam int DESTW   = 3;
   localparam int NDEST   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   address_multiply_scheduler_if #(.NREQ(NREQ), .DESTW(DESTW)) bus ();

   address_multiply_scheduler #(.NREQ(NREQ), .LATENCY(LATENCY), .DESTW(DESTW)) dut (
      .clk     (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // Multiplier stand-in: product of the issued operands appears LATENCY cycles later.
   logic [31:0] mul_pipe [LATENCY];
   always @(posedge clk) begin
      for (int i = LATENCY-1; i > 0; i--) mul_pipe[i] <= mul_pipe[i-1];
      mul_pipe[0] <= bus.o_mul_Aj * bus.o_mul_Ak;
   end
   assign bus.i_mul_Ai = mul_pipe[LATENCY-1];

   logic [NREQ-1:0]  st_v;
   logic [31:0]      st_aj   [NREQ];
   logic [31:0]      st_ak   [NREQ];
   logic [DESTW-1:0] st_dest [NREQ];
   logic             st_hold;

   // Reference model: a destination is free again at cycle rel[n][d];
   // expected results are {due_cycle, req, dest, product}.
   int          cyc;
   int          m_ptr;
   int          rel [NREQ][NDEST];
   logic [79:0] exp_q [$];
   int          checks;
   int          failures;
   int          t;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic apply;
      bus.i_req_v = st_v;
      bus.i_hold  = st_hold;
      for (int n = 0; n < NREQ; n++) begin
         bus.i_req_Aj[32*n +: 32]      = st_aj[n];
         bus.i_req_Ak[32*n +: 32]      = st_ak[n];
         bus.i_req_dest[DESTW*n +: DESTW] = st_dest[n];
      end
   endtask

   task automatic idle;
      st_v    = '0;
      st_hold = 1'b0;
   endtask

   task automatic model_clear;
      m_ptr = 0;
      for (int n = 0; n < NREQ; n++)
         for (int d = 0; d < NDEST; d++) rel[n][d] = -1000;
      exp_q.delete();
   endtask

   task automatic step;
      int          g;
      int          n;
      logic        exp_busy;
      logic [79:0] e;
      logic [31:0] prod;
      @(negedge clk);
      apply();
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         n = (m_ptr + k) % NREQ;
         if (g < 0 && st_v[n] && !st_hold && rel[n][st_dest[n]] <= cyc) g = n;
      end
      check("rdy", 64'(bus.o_req_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
      check("issue", 64'(bus.o_mul_issue), 64'(g >= 0));
      check("mul_aj", 64'(bus.o_mul_Aj), (g >= 0) ? 64'(st_aj[g]) : 64'd0);
      check("mul_ak", 64'(bus.o_mul_Ak), (g >= 0) ? 64'(st_ak[g]) : 64'd0);
      if (exp_q.size() > 0 && int'(exp_q[0][79:48]) == cyc) begin
         e = exp_q.pop_front();
         check("res_v", 64'(bus.o_res_v), 64'd1);
         check("res_req", 64'(bus.o_res_req), 64'(e[47:40]));
         check("res_dest", 64'(bus.o_res_dest), 64'(e[39:32]));
         check("res_ai", 64'(bus.o_res_Ai), 64'(e[31:0]));
      end else begin
         check("res_v_idle", 64'(bus.o_res_v), 64'd0);
      end
      exp_busy = 1'b0;
      for (int a = 0; a < NREQ; a++)
         for (int d = 0; d < NDEST; d++)
            if (rel[a][d] > cyc) exp_busy = 1'b1;
      check("busy", 64'(bus.o_busy), 64'(exp_busy));
      if (g >= 0) begin
         prod = st_aj[g] * st_ak[g];
         rel[g][st_dest[g]] = cyc + LATENCY + 1;
         exp_q.push_back({32'(cyc + LATENCY), 8'(g), 8'(st_dest[g]), prod});
         m_ptr = (g + 1) % NREQ;
      end
      cyc++;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      st_v  = '1;
      apply();
      #1;
      check("rst_rdy", 64'(bus.o_req_rdy), 64'd0);
      check("rst_issue", 64'(bus.o_mul_issue), 64'd0);
      check("rst_res_v", 64'(bus.o_res_v), 64'd0);
      check("rst_busy", 64'(bus.o_busy), 64'd0);
      idle();
      apply();
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic drain(input int ncyc);
      idle();
      for (int i = 0; i < ncyc; i++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0; cyc = 0;
      for (int n = 0; n < NREQ; n++) begin
         st_aj[n] = 32'd0; st_ak[n] = 32'd0; st_dest[n] = '0;
      end
      idle();
      apply();
      model_clear();
      #1 rst_n = 1'b0;
      do_reset();

      // Single op: 7*9 to dest 2 emerges 6 cycles after the grant.
      idle();
      st_v[0] = 1'b1; st_aj[0] = 32'd7; st_ak[0] = 32'd9; st_dest[0] = 3'd2;
      step();
      check("t1_rdy0", 64'(bus.o_req_rdy[0]), 64'd1);
      idle();
      for (int i = 1; i <= 7; i++) begin
         step();
         if (i == 6) begin
            check("t1_res_v", 64'(bus.o_res_v), 64'd1);
            check("t1_res_dest", 64'(bus.o_res_dest), 64'd2);
            check("t1_res_ai", 64'(bus.o_res_Ai), 64'd63);
         end
      end

      // Round robin with all requesters valid and dests rotating each cycle.
      do_reset();
      for (t = 0; t < 16; t++) begin
         st_v = '1; st_hold = 1'b0;
         for (int n = 0; n < NREQ; n++) begin
            st_dest[n] = 3'(t % 8); st_aj[n] = $urandom; st_ak[n] = $urandom;
         end
         step();
         check("t2_order", 64'(bus.o_req_rdy), 64'd1 << (t % 4));
      end
      drain(LATENCY + 2);

      // Scoreboard: dest 5 blocked until the cycle after its result.
      do_reset();
      for (t = 0; t < 8; t++) begin
         idle();
         st_v[1] = 1'b1; st_aj[1] = $urandom; st_ak[1] = $urandom;
         st_dest[1] = (t == 1) ? 3'd4 : 3'd5;
         step();
         if (t <= 1 || t == 7) check("t3_granted", 64'(bus.o_req_rdy[1]), 64'd1);
         else check("t3_blocked", 64'(bus.o_req_rdy[1]), 64'd0);
      end
      drain(LATENCY + 2);

      // Hold with ops in flight.
      do_reset();
      for (t = 0; t < 9; t++) begin
         idle();
         for (int n = 0; n < NREQ; n++) begin
            st_dest[n] = 3'(n + 3); st_aj[n] = $urandom; st_ak[n] = $urandom;
         end
         if (t == 0) st_v[0] = 1'b1;
         if (t == 1) st_v[2] = 1'b1;
         if (t >= 2 && t <= 4) begin st_v = '1; st_hold = 1'b1; end
         step();
         if (t >= 2 && t <= 4) check("t4_hold_rdy", 64'(bus.o_req_rdy), 64'd0);
         if (t == 6 || t == 7) check("t4_res_v", 64'(bus.o_res_v), 64'd1);
      end
      drain(LATENCY);

      // Wrap of the 32-bit product.
      do_reset();
      for (t = 0; t < 9; t++) begin
         idle();
         if (t == 0) begin st_v[0] = 1'b1; st_aj[0] = 32'hFFFF_FFFF; st_ak[0] = 32'd2; st_dest[0] = 3'd1; end
         if (t == 1) begin st_v[1] = 1'b1; st_aj[1] = 32'h0001_0000; st_ak[1] = 32'h0001_0000; st_dest[1] = 3'd1; end
         step();
         if (t == 6) check("t5_wrap", 64'(bus.o_res_Ai), 64'hFFFF_FFFE);
         if (t == 7) begin
            check("t5_sq_v", 64'(bus.o_res_v), 64'd1);
            check("t5_sq", 64'(bus.o_res_Ai), 64'd0);
         end
      end

      // Reset mid-operation: issues at 0-2, reset at 3.
      do_reset();
      for (t = 0; t < 3; t++) begin
         st_v = '1; st_hold = 1'b0;
         for (int n = 0; n < NREQ; n++) begin
            st_dest[n] = 3'(n); st_aj[n] = $urandom; st_ak[n] = $urandom;
         end
         step();
      end
      do_reset();
      drain(LATENCY + 3);
      check("t6_busy", 64'(bus.o_busy), 64'd0);
      st_v = '1;
      step();
      check("t6_ptr0", 64'(bus.o_req_rdy), 64'd1);
      step();
      check("t6_sb_clear", 64'(bus.o_req_rdy), 64'd2);
      drain(LATENCY + 2);

      // Random traffic with frequent destination conflicts.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         for (int n = 0; n < NREQ; n++) begin
            st_v[n]    = ($urandom_range(0, 99) < 60);
            st_dest[n] = 3'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
               0: st_aj[n] = 32'hFFFF_FFFF;
               default: st_aj[n] = $urandom;
            endcase
            st_ak[n] = $urandom;
         end
         st_hold = ($urandom_range(0, 99) < 10);
         step();
      end
      drain(LATENCY + 2);
      check("final_busy", 64'(bus.o_busy), 64'd0);
      check("final_q_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
